// File: rtl/ov5640_ddr_r_en_if.sv
// ============================================================================
// Module   : ov5640_ddr_r_en_if
// Brief    : Bundles the read-gate control, DDR request and pixel stream signals
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ov5640_ddr_r_en_if #(
    parameter int ADDR_W = 32
);
    logic              axi_rd_en;
    logic              s_wr_vsync;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_len;
    logic              rd_req_ack;
    logic [23:0]       s_data;
    logic              s_data_valid;
    logic              s_data_ready;
    logic [23:0]       m_data;
    logic              m_data_valid;
    logic              m_data_ready;
    logic              m_hsync;
    logic              m_vsync;
    logic              m_frame_done;
    logic              m_overrun;

    // The gate itself.
    modport master (
        input  axi_rd_en, s_wr_vsync, rd_req_ack, s_data, s_data_valid, m_data_ready,
        output rd_req, rd_addr, rd_len, s_data_ready, m_data, m_data_valid,
        output m_hsync, m_vsync, m_frame_done, m_overrun
    );

    // Everything around the gate: write path, DDR read master, FIFO, sink.
    modport slave (
        output axi_rd_en, s_wr_vsync, rd_req_ack, s_data, s_data_valid, m_data_ready,
        input  rd_req, rd_addr, rd_len, s_data_ready, m_data, m_data_valid,
        input  m_hsync, m_vsync, m_frame_done, m_overrun
    );
endinterface

`default_nettype wire

// File: rtl/ov5640_ddr_r_en.sv
// ============================================================================
// Module   : ov5640_ddr_r_en
// Brief    : Frame-gated DDR read: one whole-frame request per trigger, then
//            exactly one frame of pixels with line/frame markers.
//            Optional macro OV5640_RD_PINGPONG_EN alternates BUF0/BUF1 frames.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ov5640_ddr_r_en #(
    parameter int                H_ACTIVE      = 1280,
    parameter int                V_ACTIVE      = 720,
    parameter int                ADDR_W        = 32,
    parameter int                BYTES_PER_PIX = 4,
    parameter logic [ADDR_W-1:0] BUF0_ADDR     = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] BUF1_ADDR     = ADDR_W'(32'h0040_0000)
) (
    input  wire logic           axi_clk,
    input  wire logic           axi_rst,
    ov5640_ddr_r_en_if.master   bus
);

    localparam int          X_W      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int          Y_W      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [X_W-1:0] c_X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] c_Y_LAST = Y_W'(V_ACTIVE - 1);
    localparam logic [31:0] c_RD_LEN = 32'(H_ACTIVE * V_ACTIVE * BYTES_PER_PIX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         r_state;
    logic           r_rd_req;
    logic           r_frame_done;
    logic           r_overrun;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;

    logic           w_in_data;
    logic           w_xfer;
    logic           w_x_last;
    logic           w_y_last;
    logic           w_busy;

    assign w_in_data = (r_state == S_DATA);
    assign w_xfer    = w_in_data & bus.s_data_valid & bus.m_data_ready;
    assign w_x_last  = (r_x == c_X_LAST);
    assign w_y_last  = (r_y == c_Y_LAST);
    assign w_busy    = (r_state == S_REQ) | (r_state == S_DATA);

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_state      <= S_IDLE;
            r_rd_req     <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
        end else begin
            r_frame_done <= 1'b0;
            // A trigger while a frame is outstanding is dropped but remembered.
            if (bus.s_wr_vsync && w_busy) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.s_wr_vsync && bus.axi_rd_en) begin
                        r_state  <= S_REQ;
                        r_rd_req <= 1'b1;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (bus.rd_req_ack) begin
                        r_state  <= S_DATA;
                        r_rd_req <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        if (w_x_last) begin
                            r_x <= '0;
                            if (w_y_last) begin
                                r_y          <= '0;
                                r_state      <= S_DONE;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_y <= r_y + Y_W'(1);
                            end
                        end else begin
                            r_x <= r_x + X_W'(1);
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_rd_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef OV5640_RD_PINGPONG_EN
    logic r_buf_idx;

    // The index flips once per completed frame, so the next request reads the other buffer.
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_buf_idx <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_buf_idx <= ~r_buf_idx;
        end
    end

    assign bus.rd_addr = r_buf_idx ? BUF1_ADDR : BUF0_ADDR;
`else
    assign bus.rd_addr = BUF0_ADDR;
`endif

    assign bus.rd_req       = r_rd_req;
    assign bus.rd_len       = c_RD_LEN;
    assign bus.m_frame_done = r_frame_done;
    assign bus.m_overrun    = r_overrun;

    // Zero-latency pass-through, only open while a frame is being passed.
    assign bus.m_data       = bus.s_data;
    assign bus.m_data_valid = w_in_data & bus.s_data_valid;
    assign bus.s_data_ready = w_in_data & bus.m_data_ready;
    assign bus.m_vsync      = bus.m_data_valid & (r_x == '0) & (r_y == '0);
    assign bus.m_hsync      = bus.m_data_valid & w_x_last;

endmodule

`default_nettype wire

// File: tb/tb_ov5640_ddr_r_en.sv
// ============================================================================
// Module   : tb_ov5640_ddr_r_en
// Brief    : Self-checking bench for ov5640_ddr_r_en on an 8x4 frame
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ov5640_ddr_r_en;

    localparam int          H  = 8;
    localparam int          V  = 4;
    localparam logic [31:0] B0 = 32'h0000_0000;
    localparam logic [31:0] B1 = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ov5640_ddr_r_en_if #(.ADDR_W(32)) bus ();

    ov5640_ddr_r_en #(
        .H_ACTIVE      (H),
        .V_ACTIVE      (V),
        .ADDR_W        (32),
        .BYTES_PER_PIX (4),
        .BUF0_ADDR     (B0),
        .BUF1_ADDR     (B1)
    ) dut (
        .axi_clk (clk),
        .axi_rst (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic        sv;
        logic        mr;
        logic        trig;
        logic [23:0] pix;
        logic        exp_sr;
        logic        exp_mv;
        logic        exp_hs;
        logic        exp_vs;
    } vec_t;

    vec_t        vecs [512];
    int          n_vec;
    int          n_xfer;
    int          checks = 0;
    int          errors = 0;
    logic        exp_idx = 1'b0;
    logic [23:0] pix_base = 24'h0;
    logic [31:0] pp_exp [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_addr();
`ifdef OV5640_RD_PINGPONG_EN
        return exp_idx ? B1 : B0;
`else
        return B0;
`endif
    endfunction

    task automatic check_reset_vals();
        bus.s_data_valid = 1'b1;
        bus.m_data_ready = 1'b1;
        #1;
        chk("rst_rd_req",     32'(bus.rd_req),       0);
        chk("rst_rd_addr",    bus.rd_addr,           B0);
        chk("rst_rd_len",     bus.rd_len,            32'd128);
        chk("rst_m_valid",    32'(bus.m_data_valid), 0);
        chk("rst_s_ready",    32'(bus.s_data_ready), 0);
        chk("rst_hsync",      32'(bus.m_hsync),      0);
        chk("rst_vsync",      32'(bus.m_vsync),      0);
        chk("rst_frame_done", 32'(bus.m_frame_done), 0);
        chk("rst_overrun",    32'(bus.m_overrun),    0);
    endtask

    // Trigger with enable, hold rd_req_ack off for d cycles of rd_req, then ack.
    task automatic do_request(input int d);
        bus.axi_rd_en    = 1'b1;
        bus.s_wr_vsync   = 1'b1;
        bus.s_data_valid = 1'b1;
        bus.m_data_ready = 1'b1;
        tick();
        bus.s_wr_vsync = 1'b0;
        for (int i = 0; i < d; i++) begin
            #1;
            chk("req_rd_req",  32'(bus.rd_req),       1);
            chk("req_s_ready", 32'(bus.s_data_ready), 0);
            chk("req_m_valid", 32'(bus.m_data_valid), 0);
            tick();
        end
        bus.rd_req_ack = 1'b1;
        #1;
        chk("ack_rd_req",  32'(bus.rd_req), 1);
        chk("ack_rd_addr", bus.rd_addr,     exp_addr());
        tick();
        bus.rd_req_ack = 1'b0;
        #1;
        chk("post_ack_rd_req", 32'(bus.rd_req), 0);
    endtask

    // mode 0: continuous valid/ready; mode 1: ready toggles, valid random.
    // s_data behaves like a FIFO head: pixel k stays until it is popped.
    task automatic fill_table(input int mode, input int trig_at);
        int   k;
        vec_t v;
        k     = 0;
        n_vec = 0;
        while (k < H * V && n_vec < 512) begin
            v.sv     = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            v.mr     = (mode == 0) ? 1'b1 : ((n_vec % 2) == 1);
            v.trig   = (n_vec == trig_at);
            v.pix    = 24'hA00000 + pix_base + 24'(k);
            v.exp_sr = v.mr;
            v.exp_mv = v.sv;
            v.exp_hs = v.sv && ((k % H) == H - 1);
            v.exp_vs = v.sv && (k == 0);
            vecs[n_vec] = v;
            n_vec++;
            if (v.sv && v.mr) k++;
        end
        pix_base = pix_base + 24'h010000;
    endtask

    task automatic apply_table(input int n);
        n_xfer = 0;
        for (int i = 0; i < n; i++) begin
            bus.s_data_valid = vecs[i].sv;
            bus.m_data_ready = vecs[i].mr;
            bus.s_data       = vecs[i].pix;
            bus.s_wr_vsync   = vecs[i].trig;
            #1;
            chk("s_data_ready", 32'(bus.s_data_ready), 32'(vecs[i].exp_sr));
            chk("m_data_valid", 32'(bus.m_data_valid), 32'(vecs[i].exp_mv));
            chk("m_hsync",      32'(bus.m_hsync),      32'(vecs[i].exp_hs));
            chk("m_vsync",      32'(bus.m_vsync),      32'(vecs[i].exp_vs));
            chk("m_data",       32'(bus.m_data),       32'(vecs[i].pix));
            chk("data_rd_req",  32'(bus.rd_req),       0);
            if (bus.s_data_valid && bus.s_data_ready) n_xfer++;
            tick();
        end
        bus.s_wr_vsync   = 1'b0;
        bus.s_data_valid = 1'b1;
        bus.m_data_ready = 1'b1;
    endtask

    // Called in the cycle after the last transfer.
    task automatic finish_frame();
        #1;
        chk("frame_done",     32'(bus.m_frame_done), 1);
        chk("done_m_valid",   32'(bus.m_data_valid), 0);
        chk("done_s_ready",   32'(bus.s_data_ready), 0);
        chk("transfer_count", n_xfer,                32'(H * V));
        exp_idx = ~exp_idx;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("idle_rd_req",     32'(bus.rd_req),       0);
            chk("idle_frame_done", 32'(bus.m_frame_done), 0);
            chk("idle_s_ready",    32'(bus.s_data_ready), 0);
            tick();
        end
    endtask

    initial begin
        bus.axi_rd_en    = 1'b0;
        bus.s_wr_vsync   = 1'b0;
        bus.rd_req_ack   = 1'b0;
        bus.s_data       = 24'h0;
        bus.s_data_valid = 1'b0;
        bus.m_data_ready = 1'b0;
`ifdef OV5640_RD_PINGPONG_EN
        pp_exp[0] = B0; pp_exp[1] = B1; pp_exp[2] = B0;
`else
        pp_exp[0] = B0; pp_exp[1] = B0; pp_exp[2] = B0;
`endif
        repeat (3) tick();
        check_reset_vals();
        rst = 1'b0;
        tick();

        // Basic frame, ack three cycles after rd_req.
        do_request(3);
        fill_table(0, -1);
        apply_table(n_vec);
        finish_frame();
        tick();
        idle_cycles(2);

        // Backpressure.
        do_request(1);
        fill_table(1, -1);
        apply_table(n_vec);
        finish_frame();
        tick();
        idle_cycles(1);

        // Disabled trigger is dropped.
        bus.axi_rd_en  = 1'b0;
        bus.s_wr_vsync = 1'b1;
        tick();
        bus.s_wr_vsync = 1'b0;
        idle_cycles(3);

        // Enable falls mid-frame: frame completes, next trigger (in DONE) ignored.
        do_request(0);
        bus.axi_rd_en = 1'b0;
        fill_table(0, -1);
        apply_table(n_vec);
        finish_frame();
        bus.s_wr_vsync = 1'b1;
        tick();
        bus.s_wr_vsync = 1'b0;
        idle_cycles(3);

        // Overrun: trigger during DATA.
        #1;
        chk("overrun_before", 32'(bus.m_overrun), 0);
        do_request(2);
        fill_table(0, 5);
        apply_table(n_vec);
        chk("overrun_set", 32'(bus.m_overrun), 1);
        finish_frame();
        tick();
        idle_cycles(2);
        chk("overrun_sticky", 32'(bus.m_overrun), 1);

        rst = 1'b1;
        tick();
        rst     = 1'b0;
        exp_idx = 1'b0;
        tick();
        #1;
        chk("overrun_cleared", 32'(bus.m_overrun), 0);

        // Three back-to-back frames, each triggered in the DONE cycle.
        for (int f = 0; f < 3; f++) begin
            do_request(f);
            chk("pp_rd_addr", bus.rd_addr, pp_exp[f]);
            fill_table(0, -1);
            apply_table(n_vec);
            finish_frame();
        end
        tick();
        idle_cycles(1);

        // Reset after transfer 10, then a clean full frame.
        do_request(1);
        fill_table(0, -1);
        apply_table(11);
        rst = 1'b1;
        tick();
        check_reset_vals();
        rst     = 1'b0;
        exp_idx = 1'b0;
        tick();
        idle_cycles(2);
        do_request(2);
        fill_table(0, -1);
        apply_table(n_vec);
        finish_frame();
        tick();
        idle_cycles(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/ov5640_ddr_r_en.md
# ov5640_ddr_r_en

Read-side frame gate for the OV5640 DDR frame buffer, and the counterpart of the write-side enable gate. On each frame-start pulse from the write path it issues one whole-frame DDR read request, then passes exactly one frame of pixels from the DDR read FIFO to the PCIe/display stream. While passing the frame it generates line and frame markers and counts pixels with ready/valid backpressure. Read enable takes effect only at frame boundaries, so downstream never sees a partial frame.

## Interface
Parameters:
- H_ACTIVE, 1280, pixels per line
- V_ACTIVE, 720, lines per frame
- ADDR_W, 32, DDR byte-address width
- BYTES_PER_PIX, 4, DDR storage bytes per pixel
- BUF0_ADDR, 32'h0000_0000, frame buffer 0 base
- BUF1_ADDR, 32'h0040_0000, frame buffer 1 base (used only with the ping-pong macro)

Ports:
- axi_clk  in  1  the only clock; all logic is on its rising edge
- axi_rst  in  1  synchronous, active-high reset
- axi_rd_en  in  1  read enable, sampled only when a trigger is taken
- s_wr_vsync  in  1  one-cycle frame-start pulse from the write side; this is the trigger
- rd_req  out  1  frame read request to the DDR read master
- rd_addr  out  ADDR_W  base address of the frame being read
- rd_len  out  32  byte length, constant H_ACTIVE*V_ACTIVE*BYTES_PER_PIX
- rd_req_ack  in  1  request accepted by the read master
- s_data  in  24  RGB pixel from the DDR read FIFO
- s_data_valid  in  1  FIFO data valid
- s_data_ready  out  1  FIFO pop
- m_data  out  24  output pixel
- m_data_valid  out  1  output valid
- m_data_ready  in  1  downstream ready
- m_hsync  out  1  last pixel of a line, qualified by m_data_valid
- m_vsync  out  1  first pixel of a frame, qualified by m_data_valid
- m_frame_done  out  1  one-cycle pulse after the last pixel of a frame
- m_overrun  out  1  sticky flag: a trigger arrived while a frame was in progress

## Operation
- FSM states: IDLE, REQ, DATA, DONE. Reset state is IDLE.
- IDLE or DONE, with s_wr_vsync=1 and axi_rd_en=1: go to REQ. With axi_rd_en=0 the trigger is dropped and the FSM stays in or returns to IDLE.
- DONE with no trigger: go to IDLE.
- REQ: rd_req=1 and rd_addr is held stable. Leave REQ for DATA the cycle after the first cycle with rd_req_ack=1.
- DATA:
  - m_data = s_data; m_data_valid = s_data_valid; s_data_ready = m_data_ready. These are combinational.
  - Outside DATA, m_data_valid=0 and s_data_ready=0.
  - A transfer is a cycle with s_data_valid & m_data_ready in DATA.
  - Counter x (0..H_ACTIVE-1) advances on each transfer. When x wraps, counter y (0..V_ACTIVE-1) advances.
  - m_vsync = m_data_valid & x==0 & y==0.
  - m_hsync = m_data_valid & x==H_ACTIVE-1.
  - The transfer at x=H_ACTIVE-1 and y=V_ACTIVE-1 moves the FSM to DONE and clears x and y.
- DONE: m_frame_done=1 for exactly this cycle.
- A trigger in REQ or DATA is ignored and sets m_overrun. m_overrun clears only on reset.
- axi_rd_en falling in REQ or DATA has no effect; the current frame completes.
- Counter widths: clog2(H_ACTIVE) bits for x, clog2(V_ACTIVE) bits for y. Compute rd_len in 32 bits.

## Timing
- Reset values: rd_req=0, rd_addr=BUF0_ADDR, m_data_valid=0, s_data_ready=0, m_hsync=0, m_vsync=0, m_frame_done=0, m_overrun=0. x, y and the buffer index are 0. m_data follows s_data combinationally and has no reset value.
- Trigger at cycle t: rd_req=1 from t+1.
- rd_req_ack at cycle a: rd_req=0 and the FSM is in DATA from a+1. An ack in the same cycle that rd_req rises is valid.
- Pass-through has zero-cycle latency.
- Last transfer at cycle l: m_frame_done=1 at l+1.
- A trigger at l+1 (in DONE) gives rd_req=1 at l+2, so back-to-back frames are allowed.
- Reset asserted mid-frame forces IDLE on the next edge. Partial-frame state is discarded and no m_frame_done is produced.

## Configuration
- OV5640_RD_PINGPONG_EN defined: a buffer index toggles in DONE. rd_addr is BUF0_ADDR when the index is 0 and BUF1_ADDR when it is 1. Frame 0 reads BUF0, frame 1 reads BUF1, and so on.
- OV5640_RD_PINGPONG_EN undefined: rd_addr is always BUF0_ADDR, the index logic is absent, and BUF1_ADDR is unused.

## Test plan
- Basic frame: H_ACTIVE=8, V_ACTIVE=4, trigger with enable, ack 3 cycles after rd_req, continuous valid/ready -> rd_addr=0, rd_len=128, exactly 32 transfers, m_vsync on transfer 0, m_hsync on transfers 7/15/23/31, m_frame_done one cycle after transfer 31.
- Backpressure: toggle m_data_ready every cycle, random s_data_valid -> pixel order preserved, s_data_ready never high while m_data_ready=0, still exactly 32 transfers.
- Enable gating: trigger with axi_rd_en=0 -> no rd_req and the FSM stays in IDLE. Deassert enable mid-frame -> frame completes, the next trigger is ignored.
- Overrun: trigger during DATA -> m_overrun=1 and stays 1. The frame in progress is unaffected and no second rd_req is issued.
- Ping-pong (macro defined): three triggered frames -> rd_addr 0, 32'h0040_0000, 0. With the macro undefined -> 0, 0, 0.
- Reset mid-frame: assert axi_rst after transfer 10 -> the FSM is in IDLE next cycle, all outputs at reset values. A new trigger gives a full 32-pixel frame with m_vsync on its first pixel.
